// File: rtl/mb8_word_master.sv
// mb8_word_master: splits 16-bit cell or single-byte accesses into byte cycles on an 8-bit memory.
// Cells are big-endian (high byte at addr, low byte at addr+1); the +1 wraps modulo 2^ASZ.
module mb8_word_master #(
    parameter int ASZ = 17,
    parameter int DSZ = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic           we,
    input  logic           bmode,
    input  logic [ASZ-1:0] addr,
    input  logic [DSZ-1:0] din,
    output logic           busy,
    output logic           ack,
    output logic [DSZ-1:0] dout,
    output logic [ASZ-1:0] mem_ai,
    output logic [7:0]     mem_vi,
    output logic           mem_we,
    input  logic [7:0]     mem_vo
);
    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_HI, RD_LO, RD_TAIL, ACK} state_t;
    state_t         state;
    logic           bmode_r;
    logic [ASZ-1:0] a_r;
    logic [7:0]     lo_r;
    logic [7:0]     hi_r;
    // mem_* are loaded with the values belonging to the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ack     <= 1'b0;
            dout    <= '0;
            mem_ai  <= '0;
            mem_vi  <= '0;
            mem_we  <= 1'b0;
            bmode_r <= 1'b0;
            a_r     <= '0;
            lo_r    <= '0;
            hi_r    <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    busy    <= 1'b1;
                    bmode_r <= bmode;
                    a_r     <= addr;
                    lo_r    <= din[7:0];
                    mem_ai  <= addr;
                    mem_we  <= we;
                    if (we) mem_vi <= bmode ? din[7:0] : din[DSZ-1:8];
                    state   <= we ? WR_HI : RD_HI;
                end
                WR_HI: if (bmode_r) begin
                    mem_we <= 1'b0;
                    ack    <= 1'b1;
                    state  <= ACK;
                end else begin
                    mem_ai <= a_r + ASZ'(1);
                    mem_vi <= lo_r;
                    state  <= WR_LO;
                end
                WR_LO: begin
                    mem_we <= 1'b0;
                    ack    <= 1'b1;
                    state  <= ACK;
                end
                RD_HI: begin
                    mem_ai <= a_r + ASZ'(1);
                    state  <= RD_LO;
                end
                // mem_vo now carries the byte addressed during RD_HI
                RD_LO: if (bmode_r) begin
                    dout  <= {{(DSZ-8){1'b0}}, mem_vo};
                    ack   <= 1'b1;
                    state <= ACK;
                end else begin
                    hi_r  <= mem_vo;
                    state <= RD_TAIL;
                end
                RD_TAIL: begin
                    dout  <= {hi_r, mem_vo};
                    ack   <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mb8_word_master.sv
// tb_mb8_word_master: table vectors, corner sequences and random accesses checked
// against a byte-array reference model of big-endian cell storage.
module tb_mb8_word_master;
    logic        clk = 0, rst_n = 0, req = 0, we = 0, bmode = 0;
    logic [16:0] addr = '0, mem_ai;
    logic [15:0] din = '0, dout;
    logic        busy, ack, mem_we;
    logic [7:0]  mem_vi, mem_vo;
    logic [7:0]  ram [131072];
    logic [7:0]  model_mem [131072];
    logic [15:0] model_dout;
    int checks = 0, errors = 0;

    mb8_word_master dut (.clk(clk), .rst_n(rst_n), .req(req), .we(we), .bmode(bmode),
        .addr(addr), .din(din), .busy(busy), .ack(ack), .dout(dout), .mem_ai(mem_ai),
        .mem_vi(mem_vi), .mem_we(mem_we), .mem_vo(mem_vo));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_ai] <= mem_vi;
        mem_vo <= ram[mem_ai];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one request; lat is the cycle (after accept) in which ack was seen, 0 on timeout.
    task automatic access(input logic w, input logic b, input logic [16:0] a,
                          input logic [15:0] d, output int lat);
        int k;
        @(negedge clk);
        req = 1; we = w; bmode = b; addr = a; din = d;
        @(posedge clk); #1;
        req = 0; we = 1'($urandom); bmode = 1'($urandom); addr = 17'($urandom); din = 16'($urandom);
        chk("busy_rise", busy, 1);
        k = 1;
        while (!ack && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        lat = ack ? k : 0;
        @(posedge clk); #1;
        chk("ack_pulse", ack, 0);
        chk("busy_fall", busy, 0);
    endtask

    task automatic run(input logic w, input logic b, input logic [16:0] a,
                       input logic [15:0] d, output int lat);
        int nxt;
        nxt = (int'(a) + 1) % 131072;
        access(w, b, a, d, lat);
        if (w && b) model_mem[a] = d[7:0];
        else if (w) begin
            model_mem[a] = d[15:8];
            model_mem[nxt] = d[7:0];
        end else
            model_dout = b ? {8'h00, model_mem[a]} : {model_mem[a], model_mem[nxt]};
    endtask

    typedef struct {
        logic        w;
        logic        b;
        logic [16:0] a;
        logic [15:0] d;
        logic [15:0] exp_dout;
        int          exp_lat;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int lat, k, diff;
        logic bad;
        logic [16:0] a;
        for (int i = 0; i < 131072; i++) begin
            ram[i] = 8'h00;
            model_mem[i] = 8'h00;
        end
        model_dout = 16'h0000;
        tbl[0] = '{1'b1, 1'b0, 17'h00010, 16'h1234, 16'h0000, 3};
        tbl[1] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 16'h1234, 4};
        tbl[2] = '{1'b1, 1'b0, 17'h1FFFF, 16'hABCD, 16'h1234, 3};
        tbl[3] = '{1'b0, 1'b0, 17'h1FFFF, 16'h0000, 16'hABCD, 4};
        tbl[4] = '{1'b1, 1'b1, 17'h00100, 16'h5A77, 16'hABCD, 2};
        tbl[5] = '{1'b0, 1'b1, 17'h00100, 16'hFFFF, 16'h0077, 3};
        tbl[6] = '{1'b0, 1'b0, 17'h00100, 16'h0000, 16'h7700, 4};
        tbl[7] = '{1'b0, 1'b1, 17'h00000, 16'h0000, 16'h00CD, 3};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_ai", mem_ai, 0);
        chk("rst_mem_vi", mem_vi, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, lat);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
        end
        chk("mem_10", ram[17'h00010], 8'h12);
        chk("mem_11", ram[17'h00011], 8'h34);
        chk("mem_1ffff", ram[17'h1FFFF], 8'hAB);
        chk("mem_0", ram[17'h00000], 8'hCD);
        chk("mem_100", ram[17'h00100], 8'h77);
        chk("mem_101", ram[17'h00101], 8'h00);

        // second request held on req while the first cell write is in flight
        @(negedge clk);
        req = 1; we = 1; bmode = 0; addr = 17'h00020; din = 16'h1111;
        @(posedge clk); #1;
        addr = 17'h00200; din = 16'h2222;
        bad = 0; k = 1;
        while (!ack && k < 10) begin
            if (mem_we && mem_ai == 17'h00200) bad = 1;
            @(posedge clk); #1;
            k++;
        end
        chk("hold_lat1", ack ? k : 0, 3);
        chk("hold_no_early", bad, 0);
        @(posedge clk); #1;
        chk("hold_idle", busy, 0);
        @(posedge clk); #1;
        chk("hold_accept2", busy, 1);
        req = 0;
        k = 1;
        while (!ack && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold_lat2", ack ? k : 0, 3);
        @(posedge clk); #1;
        model_mem[17'h00020] = 8'h11; model_mem[17'h00021] = 8'h11;
        model_mem[17'h00200] = 8'h22; model_mem[17'h00201] = 8'h22;
        chk("hold_m20", ram[17'h00020], 8'h11);
        chk("hold_m21", ram[17'h00021], 8'h11);
        chk("hold_m200", ram[17'h00200], 8'h22);
        chk("hold_m201", ram[17'h00201], 8'h22);

        // reset while WR_HI of a cell write is on the bus
        run(1, 0, 17'h00400, 16'hC3A5, lat);
        @(negedge clk);
        req = 1; we = 1; bmode = 0; addr = 17'h00300; din = 16'hBEEF;
        @(posedge clk); #1;
        req = 0;
        chk("mid_wrhi_we", mem_we, 1);
        rst_n = 0;
        #1;
        chk("mid_we", mem_we, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ack", ack, 0);
        chk("mid_ai", mem_ai, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        model_dout = 16'h0000;
        chk("mid_m300", ram[17'h00300], 8'h00);
        chk("mid_m301", ram[17'h00301], 8'h00);
        run(0, 0, 17'h00400, 16'h0000, lat);
        chk("mid_rd_lat", lat, 4);
        chk("mid_rd_dout", dout, 16'hC3A5);

        for (int i = 1; i <= 16; i++) begin
            a = 17'(1 << i);
            run(1, 0, a, 16'(i * 257), lat);
        end
        for (int i = 1; i <= 16; i++) begin
            a = 17'(1 << i);
            run(0, 0, a, 16'h0000, lat);
            chk($sformatf("sweep%0d", i), dout, 16'(i * 257));
        end

        for (int n = 0; n < 300; n++) begin
            logic w, b;
            logic [15:0] d;
            w = 1'($urandom); b = 1'($urandom); d = 16'($urandom);
            case ($urandom_range(0, 2))
                0: a = 17'($urandom_range(0, 31));
                1: a = 17'h1FFF0 + 17'($urandom_range(0, 15));
                default: a = 17'($urandom);
            endcase
            run(w, b, a, d, lat);
            chk("rnd_lat", lat, 2 + (b ? 0 : 1) + (w ? 0 : 1));
            chk("rnd_dout", dout, model_dout);
        end

        diff = 0;
        for (int i = 0; i < 131072; i++) if (ram[i] !== model_mem[i]) diff++;
        chk("mem_image", diff, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mb8_word_master.md
Name: mb8_word_master

Overview:
- Bus initiator for the 8-bit single-port memory (spram8_128k, 128K x 8).
- Turns one 16-bit cell access, or one byte access, from the eForth1 core into a sequence of byte cycles on the slave port.
- Cells are big-endian: the high byte is at `addr` and the low byte at `addr+1`.
- Sits between the core's req/ack port and the memory slave, and replaces direct byte poking of the RAM.

Parameters:
- ASZ, 17, memory address width (128K bytes).
- DSZ, 16, cell width; fixed at 2 bytes.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- bmode  in  1  1 = single byte access, 0 = 16-bit cell access; sampled with req.
- addr  in  ASZ  byte address of the access (high byte for a cell).
- din  in  16  write data; byte mode uses din[7:0].
- busy  out  1  high from the accept edge until the ACK state is left.
- ack  out  1  one-cycle completion pulse.
- dout  out  16  read result; byte mode zero-extends.
- mem_ai  out  ASZ  memory address to the slave.
- mem_vi  out  8  memory write data.
- mem_we  out  1  memory write enable.
- mem_vo  in  8  memory read data; valid one clock after mem_ai is presented with mem_we=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, ack=0, mem_we=0.
  - mem_ai=0, mem_vi=0, dout=0.
  - An in-flight access is abandoned; no further memory write is issued.
- Request capture:
  - In IDLE, req=1 at a rising edge accepts the request.
  - we, bmode, addr and din are latched internally at that edge, so the inputs may change afterwards.
  - busy rises at that edge.
  - req is ignored in every other state; there is no queueing.
- Registered outputs: all mem_* outputs are registered and driven from the next state.
- States and per-cycle outputs (cycle k = the k-th clock period after the accept edge):
  - IDLE: mem_we=0. On accept, go to WR_HI if we=1, otherwise RD_HI.
  - WR_HI (cycle 1): mem_ai=A, mem_we=1.
    - mem_vi=din[15:8] for a cell; din[7:0] in byte mode.
    - Next state: ACK if bmode, else WR_LO.
  - WR_LO (cycle 2): mem_ai=A+1, mem_vi=din[7:0], mem_we=1. Next state: ACK.
  - RD_HI (cycle 1): mem_ai=A, mem_we=0. Next state: RD_LO.
  - RD_LO (cycle 2): mem_ai=A+1, mem_we=0.
    - At the edge leaving this state, capture mem_vo as the high byte, or as the only byte in byte mode.
    - Next state: ACK if bmode, else RD_TAIL.
  - RD_TAIL (cycle 3): mem_we=0; mem_ai holds A+1. At the edge leaving this state, capture mem_vo as the low byte. Next state: ACK.
  - ACK: ack=1 for exactly one cycle, mem_we=0.
    - For reads, dout is updated at the edge entering ACK.
    - busy falls at the edge leaving ACK. Next state: IDLE.
- Latencies: ack is high in cycle 2 for a byte write, cycle 3 for a cell write or byte read, and cycle 4 for a cell read.
- Back-to-back requests: the earliest next accept is the edge after ACK, since the block must be in IDLE.
- dout persistence: dout holds its value until the next read completes; writes do not alter it.
- Byte read result: dout = {8'h00, byte}.
- Address wrap: A+1 is computed modulo 2^ASZ, so A=17'h1FFFF gives a low-byte address of 17'h00000. There is no error flag.
- Reset mid-operation: after rst_n is released, the block is in IDLE with mem_we=0, and a new req is accepted normally.

Test Plan:
- Cell write then read: write 16'h1234 at 17'h00010.
  - mem[0x10]=8'h12 and mem[0x11]=8'h34.
  - ack is high in cycle 3 of the write.
  - A read of 17'h00010 gives dout=16'h1234 with ack in cycle 4.
- Wrap-around: cell write 16'hABCD at 17'h1FFFF.
  - mem[0x1FFFF]=8'hAB and mem[0x00000]=8'hCD.
  - A cell read at 17'h1FFFF returns 16'hABCD.
- Byte mode: byte write din=16'h5A77 at 17'h00100.
  - Only mem[0x100]=8'h77 changes; mem[0x101] keeps its prior 8'h00.
  - ack is high in cycle 2.
  - A byte read at 17'h00100 returns dout=16'h0077.
- Request while busy: hold req=1 with a second address of 17'h00200 during a cell write to 17'h00020.
  - Only one access completes per ack; the second is accepted only after IDLE is re-entered.
  - No write reaches 17'h00200 before the first ack.
- Reset mid-operation: drive rst_n=0 during WR_HI of a cell write 16'hBEEF to 17'h00300.
  - mem_we drops immediately; mem[0x301] is unchanged.
  - busy=0 and ack=0.
  - After release, a cell read of 17'h00400 completes normally.
- Address sweep: cell write i*16'h0101 at addresses 1<<i for i=1..16, then read all back.
  - Every dout matches, confirming all 17 address bits reach mem_ai.
